// File: rtl/image_result_tx.sv
// ---------------------------------------------------------------------------
// image_result_tx
//
// Serialises one classification result plus a binary hand mask to a
// Raspberry Pi over two GPIO lines (a slow serial clock and a data line).
// A frame is a 0xA5 sync byte, then the class byte {6'b0, class_id}, both
// MSB first, then every image pixel, starting at row 0 col 0 with the
// column index changing fastest. Each bit occupies 2*CLK_DIV fpga_clk
// cycles: tx_clk is low for CLK_DIV cycles and then high for CLK_DIV
// cycles. The Pi samples tx_data on the rising edge of tx_clk.
//
// Ports
//   i_fpga_clk      sole clock, all logic on its rising edge
//   i_rst           synchronous active-high reset
//   i_start         request one frame (accepted only while idle)
//   i_image         LENGTH*WIDTH mask, pixel (r,c) at bit r*WIDTH+c
//   i_class_id      0 rock, 1 paper, 2 scissors, 3 none
//   o_busy          high while a frame is in progress
//   o_done          one-cycle pulse when a frame completes
//   o_tx_clk        serial clock to the Pi
//   o_tx_data       serial data to the Pi
//   o_frame_active  high from the first bit until the last bit's high phase ends
// ---------------------------------------------------------------------------
module image_result_tx #(
   parameter int LENGTH  = 30,
   parameter int WIDTH   = 30,
   parameter int CLK_DIV = 1000
) (
   input  logic                      i_fpga_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [LENGTH*WIDTH-1:0]   i_image,
   input  logic [1:0]                i_class_id,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_tx_clk,
   output logic                      o_tx_data,
   output logic                      o_frame_active
);

   localparam int NPIX   = LENGTH * WIDTH;
   localparam int TOTAL  = 16 + NPIX;
   localparam int CNT_W  = $clog2(TOTAL);
   localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0]  CLASS_START = CNT_W'(8);
   localparam logic [CNT_W-1:0]  IMAGE_START = CNT_W'(16);
   localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(CLK_DIV - 1);
   localparam logic [7:0]        SYNC_BYTE   = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      CLASS,
      IMAGE,
      FINISH
   } state_t;

   state_t                r_state;
   logic [HALF_W-1:0]     r_halfCnt;
   logic [CNT_W-1:0]      r_bitCnt;
   logic                  r_txClk;
   logic                  r_txData;
   logic                  r_frameActive;
   logic                  r_busy;
   logic                  r_done;
   logic [NPIX-1:0]       r_image;
   logic [1:0]            r_classId;

   state_t                w_nextState;
   logic [HALF_W-1:0]     w_nextHalfCnt;
   logic [CNT_W-1:0]      w_nextBitCnt;
   logic                  w_nextTxClk;
   logic                  w_nextTxData;
   logic                  w_nextFrameActive;
   logic                  w_nextBusy;
   logic                  w_nextDone;
   logic                  w_capture;
   logic [CNT_W-1:0]      w_nextIdx;
   logic [TOTAL-1:0]      w_frameBits;

   // The whole frame laid out so that vector bit k is transmitted k-th.
   // The sync byte 0xA5 (1010_0101) is a bit palindrome, so its MSB-first
   // order equals its natural bit order. The class byte is reversed by
   // hand: class_id[1] goes out as frame bit 14 and class_id[0] as bit 15.
   // Image bit r*WIDTH+c is already in row-major, column-fastest order.
   assign w_frameBits = {r_image, r_classId[0], r_classId[1], 6'b0, SYNC_BYTE};

   assign w_nextIdx   = r_bitCnt + CNT_W'(1);

   // Next-state and next-output logic. All outputs are registered so the
   // GPIO pins never glitch; each branch therefore describes what the pins
   // should show in the following cycle.
   always_comb begin
      w_nextState       = r_state;
      w_nextHalfCnt     = r_halfCnt;
      w_nextBitCnt      = r_bitCnt;
      w_nextTxClk       = r_txClk;
      w_nextTxData      = r_txData;
      w_nextFrameActive = r_frameActive;
      w_nextBusy        = r_busy;
      w_nextDone        = 1'b0;
      w_capture         = 1'b0;

      case (r_state)
         IDLE: begin
            w_nextHalfCnt     = '0;
            w_nextBitCnt      = '0;
            w_nextTxClk       = 1'b0;
            w_nextTxData      = 1'b0;
            w_nextFrameActive = 1'b0;
            w_nextBusy        = 1'b0;
            if (i_start) begin
               // The first bit is always the sync MSB, so it can be driven
               // before the shadow registers have been loaded.
               w_capture         = 1'b1;
               w_nextState       = SYNC;
               w_nextTxData      = SYNC_BYTE[7];
               w_nextFrameActive = 1'b1;
               w_nextBusy        = 1'b1;
            end
         end

         SYNC, CLASS, IMAGE: begin
            if (r_halfCnt == HALF_LAST) begin
               w_nextHalfCnt = '0;
               if (!r_txClk) begin
                  w_nextTxClk = 1'b1;
               end else if (r_bitCnt == LAST_BIT) begin
                  w_nextState       = FINISH;
                  w_nextTxClk       = 1'b0;
                  w_nextTxData      = 1'b0;
                  w_nextFrameActive = 1'b0;
                  w_nextBusy        = 1'b0;
                  w_nextDone        = 1'b1;
               end else begin
                  // End of a high phase: tx_clk falls and the next bit is
                  // presented in the same cycle, so data is always settled
                  // a full low phase before the Pi samples it.
                  w_nextBitCnt = w_nextIdx;
                  w_nextTxClk  = 1'b0;
                  w_nextTxData = w_frameBits[w_nextIdx];
                  if (w_nextIdx < CLASS_START) begin
                     w_nextState = SYNC;
                  end else if (w_nextIdx < IMAGE_START) begin
                     w_nextState = CLASS;
                  end else begin
                     w_nextState = IMAGE;
                  end
               end
            end else begin
               w_nextHalfCnt = r_halfCnt + HALF_W'(1);
            end
         end

         FINISH: begin
            w_nextState       = IDLE;
            w_nextHalfCnt     = '0;
            w_nextBitCnt      = '0;
            w_nextTxClk       = 1'b0;
            w_nextTxData      = 1'b0;
            w_nextFrameActive = 1'b0;
            w_nextBusy        = 1'b0;
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over everything, including a
   // start request in the same cycle and a frame in progress.
   always_ff @(posedge i_fpga_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_halfCnt     <= '0;
         r_bitCnt      <= '0;
         r_txClk       <= 1'b0;
         r_txData      <= 1'b0;
         r_frameActive <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_halfCnt     <= w_nextHalfCnt;
         r_bitCnt      <= w_nextBitCnt;
         r_txClk       <= w_nextTxClk;
         r_txData      <= w_nextTxData;
         r_frameActive <= w_nextFrameActive;
         r_busy        <= w_nextBusy;
         r_done        <= w_nextDone;
      end
   end

   // Shadow copies of the inputs, loaded only when a frame is accepted so
   // that later changes on the input pins cannot corrupt the frame.
   always_ff @(posedge i_fpga_clk) begin
      if (i_rst) begin
         r_image   <= '0;
         r_classId <= '0;
      end else if (w_capture) begin
         r_image   <= i_image;
         r_classId <= i_class_id;
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_tx_clk       = r_txClk;
   assign o_tx_data      = r_txData;
   assign o_frame_active = r_frameActive;

endmodule

// File: tb/tb_image_result_tx.sv
// ---------------------------------------------------------------------------
// tb_image_result_tx
//
// Drives image_result_tx (4x4 image, CLK_DIV=2) cycle by cycle and compares
// every output against a frame-level reference model: once a frame is
// accepted, output cycle t (1..128) carries frame bit (t-1)/4 with tx_clk
// high in the last two cycles of each bit, and cycle 129 is the done pulse.
// Bits captured on tx_clk rising edges are also reassembled into bytes.
// ---------------------------------------------------------------------------
module tb_image_result_tx;

   localparam int L         = 4;
   localparam int W         = 4;
   localparam int CD        = 2;
   localparam int NBITS     = 16 + L * W;
   localparam int FRAME_CYC = NBITS * 2 * CD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] image = '0;
   logic [1:0]  classId = '0;
   logic        busy;
   logic        done;
   logic        txClk;
   logic        txData;
   logic        frameActive;

   always #5 clk = ~clk;

   image_result_tx #(
      .LENGTH (L),
      .WIDTH  (W),
      .CLK_DIV(CD)
   ) dut (
      .i_fpga_clk    (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_image       (image),
      .i_class_id    (classId),
      .o_busy        (busy),
      .o_done        (done),
      .o_tx_clk      (txClk),
      .o_tx_data     (txData),
      .o_frame_active(frameActive)
   );

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   mT = 0;
   int   mAcceptCyc = 0;
   logic mBits [NBITS];
   int   doneCount = 0;
   int   faCount = 0;
   int   prevDoneCyc = 0;
   bit   gapCheck = 1'b0;
   logic sampled[$];

   // What the Pi would see: tx_data captured on every tx_clk rising edge.
   always @(posedge txClk) begin
      sampled.push_back(txData);
   end

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, then drive inputs
   // for the next rising edge and advance the reference model past it.
   task automatic applyStimulus(input logic r, input logic s, input logic [15:0] img, input logic [1:0] cls);
      logic [4:0] expV;
      logic [4:0] obsV;
      logic [7:0] syncB;
      logic [7:0] clsB;
      int         k;
      int         ph;
      @(negedge clk);
      cyc++;
      expV = '0;
      if (mT >= 1 && mT <= FRAME_CYC) begin
         k    = (mT - 1) / (2 * CD);
         ph   = (mT - 1) % (2 * CD);
         expV = {1'b1, 1'b0, (ph >= CD), mBits[k], 1'b1};
      end else if (mT == FRAME_CYC + 1) begin
         expV = 5'b01000;
      end
      obsV = {busy, done, txClk, txData, frameActive};
      checkOutput("outs{busy,done,txclk,txdata,active}", 32'(obsV), 32'(expV));
      if (done === 1'b1) begin
         doneCount++;
         checkOutput("doneLatency", 32'(cyc - mAcceptCyc), 32'(FRAME_CYC + 1));
         if (gapCheck && prevDoneCyc > 0) begin
            checkOutput("doneGap", 32'(cyc - prevDoneCyc), 32'(FRAME_CYC + 2));
         end
         prevDoneCyc = cyc;
      end
      if (frameActive === 1'b1) faCount++;

      rst     = r;
      start   = s;
      image   = img;
      classId = cls;

      if (r) begin
         mT = 0;
      end else if (mT == 0) begin
         if (s) begin
            mT         = 1;
            mAcceptCyc = cyc;
            syncB      = 8'hA5;
            clsB       = {6'b0, cls};
            for (int i = 0; i < 8; i++) begin
               mBits[i]     = syncB[7 - i];
               mBits[8 + i] = clsB[7 - i];
            end
            for (int i = 0; i < L * W; i++) begin
               mBits[16 + i] = img[i];
            end
         end
      end else if (mT == FRAME_CYC + 1) begin
         mT = 0;
      end else begin
         mT++;
      end
   endtask

   // Reassembles the bits the Pi would have sampled and checks the frame.
   task automatic checkFrame(input string tag, input logic [1:0] cls, input logic [15:0] img);
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] pix;
      b0  = '0;
      b1  = '0;
      pix = '0;
      checkOutput({tag, ".bitCount"}, 32'(sampled.size()), 32'(NBITS));
      if (sampled.size() >= NBITS) begin
         for (int i = 0; i < 8; i++) begin
            b0 = {b0[6:0], sampled[i]};
            b1 = {b1[6:0], sampled[8 + i]};
         end
         for (int i = 0; i < 16; i++) begin
            pix[i] = sampled[16 + i];
         end
         checkOutput({tag, ".sync"}, 32'(b0), 32'h0000_00A5);
         checkOutput({tag, ".class"}, 32'(b1), 32'({6'b0, cls}));
         checkOutput({tag, ".pixels"}, 32'(pix), 32'(img));
      end
   endtask

   initial begin
      logic [15:0] img0;
      logic [15:0] imgT;

      // Reset state
      repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 2'd0);

      // Basic frame
      $display("[TB] basic frame");
      sampled.delete();
      doneCount = 0;
      faCount   = 0;
      applyStimulus(1'b0, 1'b1, 16'hF00F, 2'd2);
      repeat (140) applyStimulus(1'b0, 1'b0, 16'hF00F, 2'd2);
      checkFrame("basic", 2'd2, 16'hF00F);
      checkOutput("basic.doneCount", 32'(doneCount), 32'd1);
      checkOutput("basic.activeLen", 32'(faCount), 32'(FRAME_CYC));

      // Start while busy is ignored
      $display("[TB] start while busy");
      sampled.delete();
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 16'h1234, 2'd1);
      for (int c = 1; c < 140; c++) begin
         if (c >= 40 && c < 45) applyStimulus(1'b0, 1'b1, 16'hBEEF, 2'd3);
         else                   applyStimulus(1'b0, 1'b0, 16'h1234, 2'd1);
      end
      checkFrame("busyStart", 2'd1, 16'h1234);
      checkOutput("busyStart.doneCount", 32'(doneCount), 32'd1);

      // Reset in the middle of a frame, then restart
      $display("[TB] reset mid-frame");
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 16'h0FF0, 2'd3);
      repeat (69) applyStimulus(1'b0, 1'b0, 16'h0FF0, 2'd3);
      applyStimulus(1'b1, 1'b0, 16'h0FF0, 2'd3);
      repeat (20) applyStimulus(1'b0, 1'b0, 16'h0FF0, 2'd3);
      checkOutput("abort.doneCount", 32'(doneCount), 32'd0);
      sampled.delete();
      faCount = 0;
      applyStimulus(1'b0, 1'b1, 16'h5AC3, 2'd1);
      repeat (135) applyStimulus(1'b0, 1'b0, 16'h5AC3, 2'd1);
      checkFrame("restart", 2'd1, 16'h5AC3);
      checkOutput("restart.doneCount", 32'(doneCount), 32'd1);
      checkOutput("restart.activeLen", 32'(faCount), 32'(FRAME_CYC));

      // Back-to-back frames with start held high and random inputs
      $display("[TB] back-to-back");
      doneCount   = 0;
      prevDoneCyc = 0;
      gapCheck    = 1'b1;
      for (int c = 0; c < 3 * (FRAME_CYC + 2) + 5; c++) begin
         applyStimulus(1'b0, 1'b1, 16'($urandom), 2'($urandom));
      end
      repeat (135) applyStimulus(1'b0, 1'b0, 16'h0, 2'd0);
      gapCheck = 1'b0;
      checkOutput("b2b.doneCount", 32'(doneCount), 32'd4);

      // Inputs toggling every cycle after capture
      $display("[TB] input toggle after capture");
      sampled.delete();
      img0 = 16'($urandom);
      imgT = img0;
      applyStimulus(1'b0, 1'b1, img0, 2'd2);
      for (int c = 0; c < 135; c++) begin
         imgT = ~imgT;
         applyStimulus(1'b0, 1'b0, imgT, 2'($urandom));
      end
      checkFrame("toggle", 2'd2, img0);

      // Random traffic: sporadic start requests and rare resets
      $display("[TB] random traffic");
      for (int c = 0; c < 900; c++) begin
         applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                       16'($urandom), 2'($urandom));
      end
      repeat (135) applyStimulus(1'b0, 1'b0, 16'h0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
